exc_irq_ctrl: RTL and testbench
===============================

Name: exc_irq_ctrl

Overview:
Parametrised exception/interrupt controller for the single-cycle ARM (LEGv8) processor. It generalises the one-line external-IRQ handshake in the controller to N external IRQ channels, adding per-channel pending latches, masking, fixed priority, and a registered exception request. It also adds explicit in-handler state with ERet return and double-fault detection. It sits beside the controller: it consumes the decoder's synchronous-exception request and drives Exc/EStatus toward the datapath's exception-vector logic.

Parameters:
N_IRQ, 4, number of external interrupt channels (1..8)
ESTATUS_W, 4, width of the EStatus code
IRQ_CODE_BASE, 4'h8, EStatus code of channel 0; channel k reports IRQ_CODE_BASE+k

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ExtIRQ  in  N_IRQ  level interrupt requests, one bit per channel
IrqMask  in  N_IRQ  1 = channel masked (still latched as pending, never taken)
SyncExc  in  1  synchronous exception request from the decoder (invalid opcode etc.), single-cycle pulse
SyncCode  in  ESTATUS_W  code for SyncExc, valid with SyncExc
ExcAck  in  1  datapath has vectored to the handler
ERet  in  1  handler executed ERET
Exc  out  1  exception request to datapath (registered)
EStatus  out  ESTATUS_W  cause code, held while Exc=1 and throughout the handler
ExtIAck  out  N_IRQ  one-hot, one-cycle acknowledge of the serviced channel
InHandler  out  1  1 while in HANDLER state
DoubleFault  out  1  sticky; set by SyncExc while not IDLE

Behaviour:
- Reset values (next edge with reset=1, overrides everything): state=IDLE, pending=0, Exc=0, EStatus=0, ExtIAck=0, InHandler=0, DoubleFault=0.
- Pending: each cycle pending[k] <= pending[k] | ExtIRQ[k], except that the bit being acknowledged that cycle is cleared. If ExtIRQ[k] is still high, it re-sets on the following cycle (level semantics).
- Eligible set = pending & ~IrqMask. Priority: SyncExc first, then the lowest-index eligible channel.
- States: IDLE, REQ, HANDLER.
- IDLE:
  - SyncExc=1 -> REQ; EStatus<=SyncCode; Exc<=1; latched source = sync.
  - Otherwise, if any channel is eligible -> REQ; EStatus<=IRQ_CODE_BASE+k; Exc<=1; latched source = channel k.
  - Latency: request visible on Exc one cycle after SyncExc, or after the pending bit is set.
- REQ:
  - Exc=1 and EStatus are held stable; the selection is frozen even if a higher-priority IRQ arrives.
  - ExcAck=1 -> HANDLER; Exc<=0; InHandler<=1. If the source is channel k: ExtIAck[k]=1 for exactly that cycle (registered pulse, next cycle) and pending[k] is cleared.
  - IrqMask changes in REQ do not cancel the request.
- HANDLER:
  - No nesting. New IRQs only accumulate in pending.
  - ERet=1 -> IDLE; InHandler<=0; EStatus held until the next request. A request may be taken on the cycle after return.
- SyncExc in REQ or HANDLER: DoubleFault<=1 (sticky until reset); the event is otherwise ignored.
- ERet in IDLE/REQ and ExcAck in IDLE/HANDLER are ignored.
- Simultaneous ExcAck and ERet in REQ: ExcAck wins.
- Reset asserted mid-handler: immediate return to IDLE with all pending cleared.
- EStatus arithmetic: IRQ_CODE_BASE+k truncated to ESTATUS_W. Parameter choice must keep the result below 2^ESTATUS_W; an elaboration-time assertion checks this.

Decomposition:
- Shared package exc_pkg holds:
  - state enum exc_state_t {IDLE, REQ, HANDLER};
  - ESTATUS constants: ES_NONE=0, ES_INVALID_OP=4'h1, IRQ_CODE_BASE;
  - the function computing the IRQ code.
- One natural sub-module, prio_enc: parametrised lowest-index priority encoder. Inputs: eligible vector. Outputs: valid and index.
- The controller instantiates exc_irq_ctrl and drops its own ExtIAck assign.

Test Plan:
- Reset with ExtIRQ=4'b1111 held -> all outputs 0 during reset; the cycle after release pending=1111; the next cycle Exc=1, EStatus=4'h8.
- ExtIRQ[2] one-cycle pulse, IrqMask=0 -> Exc=1, EStatus=4'hA. ExcAck -> next cycle ExtIAck=4'b0100 for one cycle, InHandler=1. ERet -> InHandler=0, no re-request.
- SyncExc with SyncCode=4'h1 and ExtIRQ[0] in the same cycle -> EStatus=4'h1 first. After ExcAck and ERet, the IRQ0 request follows with EStatus=4'h8.
- IrqMask=4'b0001 with ExtIRQ=4'b0011 -> channel 1 serviced (EStatus=4'h9). Channel 0 stays pending and is taken after its mask clears.
- SyncExc while InHandler=1 -> DoubleFault=1, EStatus unchanged. DoubleFault remains 1 after ERet until reset.
- Reset asserted in HANDLER with pending=4'b1000 -> next cycle state IDLE, pending=0, Exc=0, InHandler=0.

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: shared states, cause codes and IRQ code helper for the exception controller
package exc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} exc_state_t;
  localparam logic [3:0] ES_NONE = 4'h0;
  localparam logic [3:0] ES_INVALID_OP = 4'h1;
  localparam logic [3:0] IRQ_CODE_BASE = 4'h8;
  function automatic logic [7:0] irq_code(logic [7:0] base, logic [7:0] k);
    return base + k;
  endfunction
endpackage

// File: rtl/exc_irq_ctrl_if.sv
// exc_irq_ctrl_if: interrupt/exception handshake between controller logic and datapath
interface exc_irq_ctrl_if #(parameter int N_IRQ = 4, parameter int ESTATUS_W = 4);
  logic [N_IRQ-1:0] ExtIRQ;
  logic [N_IRQ-1:0] IrqMask;
  logic SyncExc;
  logic [ESTATUS_W-1:0] SyncCode;
  logic ExcAck;
  logic ERet;
  logic Exc;
  logic [ESTATUS_W-1:0] EStatus;
  logic [N_IRQ-1:0] ExtIAck;
  logic InHandler;
  logic DoubleFault;
  modport master (
    output ExtIRQ, IrqMask, SyncExc, SyncCode, ExcAck, ERet,
    input Exc, EStatus, ExtIAck, InHandler, DoubleFault
  );
  modport slave (
    input ExtIRQ, IrqMask, SyncExc, SyncCode, ExcAck, ERet,
    output Exc, EStatus, ExtIAck, InHandler, DoubleFault
  );
endinterface

// File: rtl/exc_irq_ctrl_prio_enc.sv
// prio_enc: lowest-index-wins priority encoder
module prio_enc #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = IW'(i);
  end
endmodule

// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: N-channel IRQ pending/mask/priority plus sync exception, handler state and double fault
module exc_irq_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ESTATUS_W = 4,
  parameter logic [ESTATUS_W-1:0] IRQ_CODE_BASE = ESTATUS_W'(4'h8)
) (
  input logic clk,
  input logic reset,
  exc_irq_ctrl_if.slave bus
);
  import exc_pkg::*;
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  if (int'(IRQ_CODE_BASE) + N_IRQ > (1 << ESTATUS_W))
    $error("IRQ codes overflow EStatus width");
  exc_state_t state, state_nx;
  logic [N_IRQ-1:0] pending, eligible, ack_clr, ext_iack;
  logic [ESTATUS_W-1:0] estatus;
  logic [IW-1:0] idx, src_idx;
  logic valid, src_sync, double_fault, take, ack, ret;
  assign eligible = pending & ~bus.IrqMask;
  prio_enc #(.N(N_IRQ), .IW(IW)) u_prio (.vec(eligible), .valid(valid), .idx(idx));
  always_comb begin
    take = state == IDLE && (bus.SyncExc || valid);
    ack = state == REQ && bus.ExcAck;
    ret = state == HANDLER && bus.ERet;
    state_nx = take ? REQ : ack ? HANDLER : ret ? IDLE : state;
    ack_clr = (ack && !src_sync) ? N_IRQ'(1) << src_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      ext_iack <= '0;
      estatus <= ESTATUS_W'(ES_NONE);
      src_sync <= 1'b0;
      src_idx <= '0;
      double_fault <= 1'b0;
    end else begin
      state <= state_nx;
      pending <= (pending | bus.ExtIRQ) & ~ack_clr;
      ext_iack <= ack_clr;
      if (take) begin
        src_sync <= bus.SyncExc;
        src_idx <= idx;
        estatus <= bus.SyncExc ? bus.SyncCode : ESTATUS_W'(irq_code(8'(IRQ_CODE_BASE), 8'(idx)));
      end
      if (bus.SyncExc && state != IDLE) double_fault <= 1'b1;
    end
  end
  assign bus.Exc = state == REQ;
  assign bus.InHandler = state == HANDLER;
  assign bus.EStatus = estatus;
  assign bus.ExtIAck = ext_iack;
  assign bus.DoubleFault = double_fault;
endmodule

// File: tb/tb_exc_irq_ctrl.sv
// tb_exc_irq_ctrl: directed checks of the exception/interrupt controller
module tb_exc_irq_ctrl;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  exc_irq_ctrl_if #(.N_IRQ(4), .ESTATUS_W(4)) bus ();
  exc_irq_ctrl #(.N_IRQ(4), .ESTATUS_W(4), .IRQ_CODE_BASE(4'h8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outs(string tag, logic exc, logic [3:0] es, logic [3:0] iack, logic inh, logic df);
    chk({tag, ".Exc"}, 32'(bus.Exc), 32'(exc));
    chk({tag, ".EStatus"}, 32'(bus.EStatus), 32'(es));
    chk({tag, ".ExtIAck"}, 32'(bus.ExtIAck), 32'(iack));
    chk({tag, ".InHandler"}, 32'(bus.InHandler), 32'(inh));
    chk({tag, ".DoubleFault"}, 32'(bus.DoubleFault), 32'(df));
  endtask
  initial begin
    bus.ExtIRQ = 4'b1111; bus.IrqMask = 0; bus.SyncExc = 0; bus.SyncCode = 0;
    bus.ExcAck = 0; bus.ERet = 0;
    tick(); tick();
    outs("rst", 0, 4'h0, 4'b0000, 0, 0);
    reset = 0;
    tick();
    chk("rel.pending", 32'(dut.pending), 32'hF);
    chk("rel.Exc", 32'(bus.Exc), 0);
    bus.ExtIRQ = 0;
    tick();
    outs("rel.req", 1, 4'h8, 4'b0000, 0, 0);
    reset = 1; tick(); reset = 0;
    bus.ExtIRQ = 4'b0100; tick(); bus.ExtIRQ = 0;
    chk("irq2.lat", 32'(bus.Exc), 0);
    tick();
    outs("irq2.req", 1, 4'hA, 4'b0000, 0, 0);
    bus.ExcAck = 1; tick(); bus.ExcAck = 0;
    outs("irq2.ack", 0, 4'hA, 4'b0100, 1, 0);
    tick();
    chk("irq2.ackpulse", 32'(bus.ExtIAck), 0);
    bus.ERet = 1; tick(); bus.ERet = 0;
    outs("irq2.ret", 0, 4'hA, 4'b0000, 0, 0);
    tick();
    chk("irq2.noreq", 32'(bus.Exc), 0);
    bus.SyncExc = 1; bus.SyncCode = 4'h1; bus.ExtIRQ = 4'b0001;
    tick();
    bus.SyncExc = 0; bus.SyncCode = 0; bus.ExtIRQ = 0;
    outs("sync.req", 1, 4'h1, 4'b0000, 0, 0);
    bus.ExcAck = 1; tick(); bus.ExcAck = 0;
    outs("sync.ack", 0, 4'h1, 4'b0000, 1, 0);
    bus.ERet = 1; tick(); bus.ERet = 0;
    outs("sync.ret", 0, 4'h1, 4'b0000, 0, 0);
    tick();
    outs("sync.irq0", 1, 4'h8, 4'b0000, 0, 0);
    bus.ExcAck = 1; tick(); bus.ExcAck = 0;
    chk("sync.irq0ack", 32'(bus.ExtIAck), 32'b0001);
    bus.ERet = 1; tick(); bus.ERet = 0;
    bus.IrqMask = 4'b0001; bus.ExtIRQ = 4'b0011;
    tick();
    bus.ExtIRQ = 0;
    tick();
    outs("mask.req1", 1, 4'h9, 4'b0000, 0, 0);
    bus.IrqMask = 4'b0011;
    tick();
    chk("mask.held", 32'(bus.Exc), 1);
    bus.ExcAck = 1; tick(); bus.ExcAck = 0;
    outs("mask.ack1", 0, 4'h9, 4'b0010, 1, 0);
    bus.ERet = 1; tick(); bus.ERet = 0;
    tick();
    chk("mask.ch0held", 32'(bus.Exc), 0);
    chk("mask.pending", 32'(dut.pending), 32'b0001);
    bus.IrqMask = 0;
    tick();
    outs("mask.req0", 1, 4'h8, 4'b0000, 0, 0);
    bus.ExcAck = 1; bus.ERet = 1; tick(); bus.ExcAck = 0; bus.ERet = 0;
    outs("both.ack", 0, 4'h8, 4'b0001, 1, 0);
    bus.SyncExc = 1; bus.SyncCode = 4'h1; tick(); bus.SyncExc = 0; bus.SyncCode = 0;
    outs("df.set", 0, 4'h8, 4'b0000, 1, 1);
    bus.ERet = 1; tick(); bus.ERet = 0;
    outs("df.sticky", 0, 4'h8, 4'b0000, 0, 1);
    bus.SyncExc = 1; bus.SyncCode = 4'h1; bus.ExtIRQ = 4'b1000;
    tick();
    bus.SyncExc = 0; bus.SyncCode = 0; bus.ExtIRQ = 0;
    bus.ExcAck = 1; tick(); bus.ExcAck = 0;
    chk("rsth.inh", 32'(bus.InHandler), 1);
    chk("rsth.pending", 32'(dut.pending), 32'b1000);
    reset = 1; tick(); reset = 0;
    outs("rsth.rst", 0, 4'h0, 4'b0000, 0, 0);
    chk("rsth.pend0", 32'(dut.pending), 0);
    tick();
    chk("rsth.noreq", 32'(bus.Exc), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
